// File: rtl/mac_sequencer_pkg.sv
// mac_ctrl_pkg: shared definitions for the MAC lane sequencer.
//   - state_e  : sequencer state enumeration
//   - ACC_W    : accumulator width (bits)
//   - OP_W     : operand width (bits)
//   - N_MAX    : largest matrix dimension whose worst-case inner product
//                still fits the accumulator
//   - IDX_W    : width of the i/j/k loop counters
//   - n_legal  : range check for the matrix dimension parameter
package mac_ctrl_pkg;

    localparam int ACC_W = 10;
    localparam int OP_W  = 8;

    // Each term is at most (2^OP_W - 1), so N terms must not exceed 2^ACC_W - 1.
    localparam int N_MAX = ((1 << ACC_W) - 1) / ((1 << OP_W) - 1);

    localparam int IDX_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        LAST,
        WRITE,
        DONE
    } state_e;

    function automatic bit n_legal(input int n);
        return (n >= 1) && (n <= N_MAX);
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// mac_seq_if: handshake and buffer-control bundle of the MAC sequencer.
//   start, stall             : from top-level control into the sequencer
//   busy, done               : status back to top-level control
//   rd_en, a_addr, b_addr    : operand buffer reads
//   acc_clear, acc_ld        : accumulate mux controls
//   res_we, res_addr         : result buffer write
// Modport master is the sequencer side; slave is the environment side.
interface mac_seq_if #(
    parameter int AW = 4
);

    logic          start;
    logic          stall;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          acc_clear;
    logic          acc_ld;
    logic          res_we;
    logic [AW-1:0] res_addr;

    modport master (
        input  start,
        input  stall,
        output busy,
        output done,
        output rd_en,
        output a_addr,
        output b_addr,
        output acc_clear,
        output acc_ld,
        output res_we,
        output res_addr
    );

    modport slave (
        output start,
        output stall,
        input  busy,
        input  done,
        input  rd_en,
        input  a_addr,
        input  b_addr,
        input  acc_clear,
        input  acc_ld,
        input  res_we,
        input  res_addr
    );

endinterface

// File: rtl/mac_index_gen.sv
// mac_index_gen: i/j/k loop counters and buffer address generation.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : return all counters to zero
//   k_adv      : advance k, wrapping to 0 after N-1
//   ij_adv     : advance j, wrapping to 0 and advancing i (i wraps too)
//   rd_en      : operand read strobe this cycle (selects live a/b address)
//   res_we     : result write strobe this cycle (selects live result address)
//   k_last, j_last, i_last : counter currently at N-1
//   a_addr = i*N+k, b_addr = k*N+j, res_addr = i*N+j; each holds its last
//   strobed value while its strobe is low.
module mac_index_gen
    import mac_ctrl_pkg::*;
#(
    parameter int N  = 3,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          k_adv,
    input  logic          ij_adv,
    input  logic          rd_en,
    input  logic          res_we,
    output logic          k_last,
    output logic          j_last,
    output logic          i_last,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic [AW-1:0] res_addr
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [AW-1:0]    a_hold_q, a_hold_d;
    logic [AW-1:0]    b_hold_q, b_hold_d;
    logic [AW-1:0]    r_hold_q, r_hold_d;
    logic [AW-1:0]    a_cur, b_cur, r_cur;

    // Multiply by the constant N as a sum of shifted copies, one per set bit.
    function automatic logic [AW-1:0] mul_n(input logic [AW-1:0] x);
        logic [AW-1:0] sum;
        sum = '0;
        for (int b = 0; b <= IDX_W; b++) begin
            if (((N >> b) & 1) == 1) begin
                sum = sum + (x << b);
            end
        end
        return sum;
    endfunction

    assign k_last = (k_q == IDX_MAX);
    assign j_last = (j_q == IDX_MAX);
    assign i_last = (i_q == IDX_MAX);

    assign a_cur = mul_n(AW'(i_q)) + AW'(k_q);
    assign b_cur = mul_n(AW'(k_q)) + AW'(j_q);
    assign r_cur = mul_n(AW'(i_q)) + AW'(j_q);

    // Addresses are live while their strobe is high and otherwise replay
    // the last strobed value, so buffers never see a spurious address change.
    assign a_addr   = rd_en  ? a_cur : a_hold_q;
    assign b_addr   = rd_en  ? b_cur : b_hold_q;
    assign res_addr = res_we ? r_cur : r_hold_q;

    always_comb begin
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        a_hold_d = a_addr;
        b_hold_d = b_addr;
        r_hold_d = res_addr;
        if (clr) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else begin
            if (k_adv) begin
                k_d = k_last ? '0 : k_q + 1'b1;
            end
            // j is the fast index; i only moves when j wraps.
            if (ij_adv) begin
                if (j_last) begin
                    j_d = '0;
                    i_d = i_last ? '0 : i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_hold_q <= '0;
            b_hold_q <= '0;
            r_hold_q <= '0;
        end else begin
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            a_hold_q <= a_hold_d;
            b_hold_q <= b_hold_d;
            r_hold_q <= r_hold_d;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: control sequencer for one accumulating MAC lane.
// Walks every element of an NxN result (row-major) and, per element,
// clears the accumulator, streams N operand reads and accumulations,
// then writes the sum to the result buffer. A one-cycle done pulse
// follows the final write.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : mac_seq_if master modport (start/stall in; busy/done,
//           operand read, accumulate controls and result write out)
module mac_sequencer
    import mac_ctrl_pkg::*;
#(
    parameter int N  = 3,
    parameter int AW = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    mac_seq_if.master bus
);

    if (!n_legal(N)) begin : g_bad_n
        $error("mac_sequencer: N must be in 1..%0d", N_MAX);
    end
    if ((1 << AW) < N * N) begin : g_bad_aw
        $error("mac_sequencer: AW too small for N*N addresses");
    end

    state_e state_q, state_d;

    logic idx_clr;
    logic k_adv;
    logic ij_adv;
    logic rd_en;
    logic acc_clear;
    logic acc_ld;
    logic res_we;
    logic done;
    logic k_last;
    logic j_last;
    logic i_last;

    mac_index_gen #(
        .N  (N),
        .AW (AW)
    ) u_index_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (idx_clr),
        .k_adv    (k_adv),
        .ij_adv   (ij_adv),
        .rd_en    (rd_en),
        .res_we   (res_we),
        .k_last   (k_last),
        .j_last   (j_last),
        .i_last   (i_last),
        .a_addr   (bus.a_addr),
        .b_addr   (bus.b_addr),
        .res_addr (bus.res_addr)
    );

    // Next state and strobes. Everything outside IDLE is frozen by stall,
    // which leaves all strobes and counter advances at their zero defaults.
    always_comb begin
        state_d   = state_q;
        idx_clr   = 1'b0;
        k_adv     = 1'b0;
        ij_adv    = 1'b0;
        rd_en     = 1'b0;
        acc_clear = 1'b0;
        acc_ld    = 1'b0;
        res_we    = 1'b0;
        done      = 1'b0;
        if (state_q == IDLE) begin
            if (bus.start) begin
                idx_clr = 1'b1;
                state_d = CLR;
            end
        end else if (!bus.stall) begin
            case (state_q)
                CLR: begin
                    acc_clear = 1'b1;
                    rd_en     = 1'b1;
                    k_adv     = 1'b1;
                    // With N=1 the k=0 read is also the final one.
                    state_d   = k_last ? LAST : RUN;
                end
                RUN: begin
                    acc_ld  = 1'b1;
                    rd_en   = 1'b1;
                    k_adv   = 1'b1;
                    state_d = k_last ? LAST : RUN;
                end
                LAST: begin
                    acc_ld  = 1'b1;
                    state_d = WRITE;
                end
                WRITE: begin
                    res_we  = 1'b1;
                    ij_adv  = 1'b1;
                    state_d = (i_last && j_last) ? DONE : CLR;
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done;
    assign bus.rd_en     = rd_en;
    assign bus.acc_clear = acc_clear;
    assign bus.acc_ld    = acc_ld;
    assign bus.res_we    = res_we;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: self-checking bench for mac_sequencer.
// An N=3 instance runs against an event-list reference model and a small
// operand/accumulator/result datapath; an N=1 instance is checked against
// hand-computed cycle positions.
module tb_mac_sequencer;

    localparam int N3 = 3;

    logic clk;
    logic rst_n;

    mac_seq_if #(.AW(4)) bus3 ();
    mac_seq_if #(.AW(4)) bus1 ();

    mac_sequencer #(.N(3), .AW(4)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.master)
    );

    mac_sequencer #(.N(1), .AW(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One expected cycle of the N=3 sequencer while it is active and not stalled.
    typedef struct {
        bit       clr;
        bit       ld;
        bit       rd;
        bit       we;
        bit       dn;
        bit [3:0] a;
        bit [3:0] b;
        bit [3:0] r;
    } ev_t;

    ev_t q3[$];
    ev_t m_e;
    ev_t c_e;
    bit [3:0] last_a = 0;
    bit [3:0] last_b = 0;
    bit [3:0] last_r = 0;
    bit model_on = 0;

    function automatic ev_t mk(bit clr, bit ld, bit rd, bit we, bit dn, int a, int b, int r);
        ev_t e;
        e.clr = clr; e.ld = ld; e.rd = rd; e.we = we; e.dn = dn;
        e.a = 4'(a); e.b = 4'(b); e.r = 4'(r);
        return e;
    endfunction

    // Build the whole product as an ordered list of per-cycle actions.
    task automatic fillModel();
        for (int i = 0; i < N3; i++) begin
            for (int j = 0; j < N3; j++) begin
                q3.push_back(mk(1, 0, 1, 0, 0, i * N3, j, 0));
                for (int k = 1; k < N3; k++) begin
                    q3.push_back(mk(0, 1, 1, 0, 0, i * N3 + k, k * N3 + j, 0));
                end
                q3.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
                q3.push_back(mk(0, 0, 0, 1, 0, 0, 0, i * N3 + j));
            end
        end
        q3.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    endtask

    // Model progress at each rising edge: reset drops the list, a stall
    // keeps the current action pending, start fills an empty list.
    always @(posedge clk) begin
        if (model_on) begin
            if (!rst_n) begin
                q3.delete();
                last_a = 0;
                last_b = 0;
                last_r = 0;
            end else if (q3.size() != 0) begin
                if (!bus3.stall) begin
                    m_e = q3.pop_front();
                    if (m_e.rd) begin
                        last_a = m_e.a;
                        last_b = m_e.b;
                    end
                    if (m_e.we) last_r = m_e.r;
                end
            end else if (bus3.start) begin
                fillModel();
            end
        end
    end

    // Per-cycle comparison of every N=3 output against the model.
    always @(negedge clk) begin
        if (model_on) begin
            logic [31:0] act;
            logic [31:0] exp;
            bit busy_e;
            busy_e = (q3.size() != 0);
            c_e = mk(0, 0, 0, 0, 0, 0, 0, 0);
            if (busy_e && !bus3.stall) c_e = q3[0];
            act = {14'd0, bus3.busy, bus3.done, bus3.rd_en, bus3.acc_clear, bus3.acc_ld,
                   bus3.res_we, bus3.a_addr, bus3.b_addr, bus3.res_addr};
            exp = {14'd0, busy_e, c_e.dn, c_e.rd, c_e.clr, c_e.ld, c_e.we,
                   c_e.rd ? c_e.a : last_a, c_e.rd ? c_e.b : last_b, c_e.we ? c_e.r : last_r};
            checkOutput("cycle_model", act, exp);
        end
    end

    // Operand buffers, accumulate mux (clear wins) and result buffer.
    // x is the product clipped to 15.
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [9:0] mem_r [16];
    logic [7:0] rd_a = 0;
    logic [7:0] rd_b = 0;
    logic [9:0] acc  = 0;
    logic [15:0] prod;
    logic [9:0]  x;
    int we_cnt3 = 0;

    assign prod = rd_a * rd_b;
    assign x    = (prod > 16'd15) ? 10'd15 : prod[9:0];

    always @(posedge clk) begin
        if (bus3.rd_en) begin
            rd_a <= mem_a[bus3.a_addr];
            rd_b <= mem_b[bus3.b_addr];
        end
        if (bus3.acc_clear)   acc <= 10'd0;
        else if (bus3.acc_ld) acc <= acc + x;
        if (bus3.res_we) begin
            mem_r[bus3.res_addr] <= acc;
            we_cnt3 <= we_cnt3 + 1;
        end
    end

    task automatic applyStimulus(input bit s3, input bit st3, input bit s1, input bit rn);
        bus3.start = s3;
        bus3.stall = st3;
        bus1.start = s1;
        bus1.stall = 1'b0;
        rst_n      = rn;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic loadOperands(input logic [7:0] v);
        for (int n = 0; n < 16; n++) begin
            mem_a[n] = v;
            mem_b[n] = v;
            mem_r[n] = 10'h3FF;
        end
    endtask

    initial begin
        int seen;
        int we_before;
        loadOperands(8'd1);
        applyStimulus(0, 0, 0, 0);
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("reset_dut3", {14'd0, bus3.busy, bus3.done, bus3.rd_en, bus3.acc_clear, bus3.acc_ld,
                    bus3.res_we, bus3.a_addr, bus3.b_addr, bus3.res_addr}, 32'd0);
        checkOutput("reset_dut1", {14'd0, bus1.busy, bus1.done, bus1.rd_en, bus1.acc_clear, bus1.acc_ld,
                    bus1.res_we, bus1.a_addr, bus1.b_addr, bus1.res_addr}, 32'd0);
        model_on = 1;
        nextCycle();
        applyStimulus(0, 0, 0, 1);
        repeat (2) nextCycle();

        // Nominal N=3 run with all-ones operands.
        $display("[TB] nominal run");
        applyStimulus(1, 0, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 1);
        for (int c = 1; c <= 47; c++) begin
            @(negedge clk);
            case (c)
                1:  checkOutput("nom_c1", {bus3.acc_clear, bus3.rd_en, bus3.a_addr, bus3.b_addr}, {2'b11, 4'd0, 4'd0});
                2:  checkOutput("nom_c2", {bus3.acc_ld, bus3.a_addr, bus3.b_addr}, {1'b1, 4'd1, 4'd3});
                5:  checkOutput("nom_c5", {bus3.res_we, bus3.res_addr}, {1'b1, 4'd0});
                10: checkOutput("nom_c10", {bus3.res_we, bus3.res_addr}, {1'b1, 4'd1});
                46: checkOutput("nom_c46_done", {31'd0, bus3.done}, 32'd1);
                47: checkOutput("nom_c47_busy", {31'd0, bus3.busy}, 32'd0);
                default: ;
            endcase
            nextCycle();
        end
        for (int n = 0; n < 9; n++) checkOutput($sformatf("ones_r%0d", n), {22'd0, mem_r[n]}, 32'd3);

        // Datapath with 0x0F operands: each term clips to 15.
        $display("[TB] 0x0F run");
        loadOperands(8'h0F);
        applyStimulus(1, 0, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 1);
        seen = 0;
        for (int c = 1; c <= 60 && seen == 0; c++) begin
            @(negedge clk);
            if (bus3.done) seen = 1;
            nextCycle();
        end
        checkOutput("f_done_seen", {31'd0, 1'(seen)}, 32'd1);
        nextCycle();
        for (int n = 0; n < 9; n++) checkOutput($sformatf("f_r%0d", n), {22'd0, mem_r[n]}, 32'd45);

        // Stall in IDLE alongside start, then three stalled RUN cycles.
        $display("[TB] stall run");
        loadOperands(8'd1);
        applyStimulus(1, 1, 0, 1);
        nextCycle();
        for (int c = 1; c <= 50; c++) begin
            applyStimulus(0, (c >= 3 && c <= 5), 0, 1);
            @(negedge clk);
            case (c)
                1:  checkOutput("st_c1", {bus3.acc_clear, bus3.rd_en}, 2'b11);
                3:  checkOutput("st_c3_quiet", {bus3.rd_en, bus3.acc_ld, bus3.acc_clear, bus3.res_we, bus3.done}, 5'b0);
                4:  checkOutput("st_c4_hold", {bus3.busy, bus3.a_addr, bus3.b_addr}, {1'b1, 4'd1, 4'd3});
                6:  checkOutput("st_c6", {bus3.acc_ld, bus3.rd_en, bus3.a_addr, bus3.b_addr}, {2'b11, 4'd2, 4'd6});
                8:  checkOutput("st_c8", {bus3.res_we, bus3.res_addr}, {1'b1, 4'd0});
                49: checkOutput("st_c49_done", {31'd0, bus3.done}, 32'd1);
                50: checkOutput("st_c50_busy", {31'd0, bus3.busy}, 32'd0);
                default: ;
            endcase
            nextCycle();
        end
        for (int n = 0; n < 9; n++) checkOutput($sformatf("st_r%0d", n), {22'd0, mem_r[n]}, 32'd3);

        // Start pulse while busy must be ignored.
        $display("[TB] start while busy");
        applyStimulus(1, 0, 0, 1);
        nextCycle();
        for (int c = 1; c <= 52; c++) begin
            applyStimulus((c == 20), 0, 0, 1);
            @(negedge clk);
            case (c)
                46: checkOutput("sb_c46_done", {31'd0, bus3.done}, 32'd1);
                47: checkOutput("sb_c47_busy", {31'd0, bus3.busy}, 32'd0);
                52: checkOutput("sb_c52_busy", {31'd0, bus3.busy}, 32'd0);
                default: ;
            endcase
            nextCycle();
        end

        // Reset held two cycles mid-RUN abandons the product.
        $display("[TB] reset mid-run");
        applyStimulus(1, 0, 0, 1);
        nextCycle();
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(0, 0, 0, !(c == 2 || c == 3));
            @(negedge clk);
            case (c)
                2: checkOutput("rs_c2_run", {31'd0, bus3.acc_ld}, 32'd1);
                4: checkOutput("rs_c4_zero", {14'd0, bus3.busy, bus3.done, bus3.rd_en, bus3.acc_clear, bus3.acc_ld,
                               bus3.res_we, bus3.a_addr, bus3.b_addr, bus3.res_addr}, 32'd0);
                default: ;
            endcase
            nextCycle();
        end
        we_before = we_cnt3;
        repeat (15) nextCycle();
        checkOutput("rs_no_write", 32'(we_cnt3 - we_before), 32'd0);

        // N=1 instance: CLR, LAST, WRITE, DONE.
        $display("[TB] N=1 run");
        applyStimulus(0, 0, 1, 1);
        nextCycle();
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(0, 0, 0, 1);
            @(negedge clk);
            case (c)
                1: checkOutput("n1_c1", {bus1.busy, bus1.acc_clear, bus1.rd_en, bus1.acc_ld, bus1.res_we, bus1.done}, 6'b111000);
                2: checkOutput("n1_c2", {bus1.busy, bus1.acc_clear, bus1.rd_en, bus1.acc_ld, bus1.res_we, bus1.done}, 6'b100100);
                3: checkOutput("n1_c3", {bus1.busy, bus1.acc_clear, bus1.rd_en, bus1.acc_ld, bus1.res_we, bus1.done, bus1.res_addr},
                               {6'b100010, 4'd0});
                4: checkOutput("n1_c4", {bus1.busy, bus1.acc_clear, bus1.rd_en, bus1.acc_ld, bus1.res_we, bus1.done}, 6'b100001);
                5: checkOutput("n1_c5", {31'd0, bus1.busy}, 32'd0);
                default: ;
            endcase
            nextCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
